time_set_controller: RTL and testbench

- Front-end sequencer for the clock/calendar time-set path.
- Synchronises and debounces three raw pushbuttons and runs a set-mode FSM that cycles through the fields hour, minute, century, year, month and day.
- Shares the single increment button among the six add_* inputs of the clock/calendar block as one-cycle pulses, with auto-repeat while the button is held.
- Sits between the board buttons and the clock/calendar block; field_sel and blink drive the pixel generator's highlight.

---
 rtl/time_set_controller.sv | 202 ++++++++++++++++++++
 tb/tb_time_set_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Time-set front end: button conditioning, set-mode FSM, auto-repeat.
// Optional field blink enabled by defining TIME_SET_BLINK_EN.
module time_set_controller #(
  parameter int unsigned DB_CYCLES      = 1000000,
  parameter int unsigned REPEAT_DELAY   = 50000000,
  parameter int unsigned REPEAT_PERIOD  = 10000000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000000,
  parameter int unsigned BLINK_HALF     = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ampm,
  output logic       add_hour,
  output logic       add_min,
  output logic       add_cen,
  output logic       add_year,
  output logic       add_month,
  output logic       add_day,
  output logic       am_or_pm,
  output logic       set_active,
  output logic [2:0] field_sel,
  output logic       blink
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    HOUR  = 3'd1,
    MIN   = 3'd2,
    CEN   = 3'd3,
    YEAR  = 3'd4,
    MONTH = 3'd5,
    DAY   = 3'd6
  } state_t;

  state_t      state, state_n, nxt;
  logic [2:0]  raw, s1, s2, lvl, lvl_q, press;
  logic [31:0] db_cnt [3];
  logic [31:0] rep_cnt, idle_cnt, lim;
  logic        rep_run, armed;
  logic        set, mode_p, inc_p, ampm_p, any_p;
  logic        rep_hit, rep_fire, tmo, inc_ok, keep;
  logic [5:0]  add_n, add_q;
  logic        ampm_n, ampm_q;

  assign raw    = {btn_ampm, btn_inc, btn_mode};
  assign press  = lvl & ~lvl_q;
  assign mode_p = press[0];
  assign inc_p  = press[1];
  assign ampm_p = press[2];
  assign any_p  = |press;
  assign set    = (state != RUN);

  // Synchronise and debounce; level moves only after a stable run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_q <= lvl;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_CYCLES - 1) begin
          lvl[i]    <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign lim      = rep_run ? REPEAT_PERIOD - 1 : REPEAT_DELAY - 1;
  assign rep_hit  = set && armed && lvl[1] && (rep_cnt == lim);
  assign tmo      = set && !any_p && !rep_hit &&
                    (idle_cnt == TIMEOUT_CYCLES - 1);
  assign rep_fire = rep_hit && !mode_p;
  assign inc_ok   = set && !mode_p && (inc_p || rep_fire);
  assign keep     = set && lvl[1] && !mode_p && !tmo;

  // Next state and next pulse values; mode beats everything else.
  always_comb begin
    state_n = state;
    add_n   = '0;
    ampm_n  = 1'b0;
    case (state)
      RUN:     nxt = HOUR;
      HOUR:    nxt = MIN;
      MIN:     nxt = CEN;
      CEN:     nxt = YEAR;
      YEAR:    nxt = MONTH;
      MONTH:   nxt = DAY;
      default: nxt = RUN;
    endcase
    unique case (1'b1)
      mode_p:  state_n = nxt;
      tmo:     state_n = RUN;
      default: ;
    endcase
    if (inc_ok) begin
      case (state)
        HOUR:    add_n[0] = 1'b1;
        MIN:     add_n[1] = 1'b1;
        CEN:     add_n[2] = 1'b1;
        YEAR:    add_n[3] = 1'b1;
        MONTH:   add_n[4] = 1'b1;
        DAY:     add_n[5] = 1'b1;
        default: ;
      endcase
    end
    ampm_n = ampm_p && !mode_p && (state == HOUR);
  end

  // State and registered one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      add_q  <= '0;
      ampm_q <= 1'b0;
    end else begin
      state  <= state_n;
      add_q  <= add_n;
      ampm_q <= ampm_n;
    end
  end

  // Auto-repeat: armed by a real inc pulse, dropped on release/change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt <= '0;
      rep_run <= 1'b0;
      armed   <= 1'b0;
    end else if (inc_ok && inc_p) begin
      rep_cnt <= '0;
      rep_run <= 1'b0;
      armed   <= 1'b1;
    end else if (!keep || !armed) begin
      rep_cnt <= '0;
      rep_run <= 1'b0;
      armed   <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt <= '0;
      rep_run <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 32'd1;
    end
  end

  // Idle timer; any press or repeat pulse counts as activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (!set || any_p || rep_fire || tmo) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

`ifdef TIME_SET_BLINK_EN
  logic [31:0] blink_cnt;
  logic        blink_q;

  // Blink while editing; stay visible on change or increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (!set || (state_n != state) || inc_ok) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BLINK_HALF - 1) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b1;
`endif

  assign add_hour   = add_q[0];
  assign add_min    = add_q[1];
  assign add_cen    = add_q[2];
  assign add_year   = add_q[3];
  assign add_month  = add_q[4];
  assign add_day    = add_q[5];
  assign am_or_pm   = ampm_q;
  assign set_active = set;
  assign field_sel  = state;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller.
// Small parameters keep debounce, repeat and timeout short.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_ampm = 1'b0;
  logic       add_hour, add_min, add_cen, add_year;
  logic       add_month, add_day, am_or_pm;
  logic       set_active, blink;
  logic [2:0] field_sel;

  always #5 clk = ~clk;

  time_set_controller #(
    .DB_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5),
    .TIMEOUT_CYCLES(100),
    .BLINK_HALF(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .btn_ampm(btn_ampm),
    .add_hour(add_hour),
    .add_min(add_min),
    .add_cen(add_cen),
    .add_year(add_year),
    .add_month(add_month),
    .add_day(add_day),
    .am_or_pm(am_or_pm),
    .set_active(set_active),
    .field_sel(field_sel),
    .blink(blink)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [6:0] pv;
  assign pv = {am_or_pm, add_day, add_month, add_year,
               add_cen, add_min, add_hour};

  int         cyc = 0;
  int         pc [7];
  int         multi = 0;
  int         fchg = 0;
  logic [2:0] fprev = 3'd0;
  int         mq [$];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 7; i++) pc[i] += int'(pv[i]);
    if ($countones(pv[5:0]) > 1) multi++;
    if (field_sel != fprev) fchg++;
    fprev = field_sel;
    if (add_month) mq.push_back(cyc);
  end

  task automatic clr();
    for (int i = 0; i < 7; i++) pc[i] = 0;
  endtask

  function automatic int add_sum();
    int s = 0;
    for (int i = 0; i < 6; i++) s += pc[i];
    return s;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] b);
    btn_mode = b[0];
    btn_inc  = b[1];
    btn_ampm = b[2];
  endtask

  task automatic press(input logic [2:0] b);
    drive(b);
    wait_cyc(8);
    drive(3'b000);
    wait_cyc(8);
  endtask

  int offs [5] = '{0, 20, 25, 30, 35};
  int found;

  initial begin
    for (int i = 0; i < 7; i++) pc[i] = 0;
    wait_cyc(3);
    check("rst_field", 32'(field_sel), 0);
    check("rst_set", 32'(set_active), 0);
    check("rst_blink", 32'(blink), 1);
    check("rst_pulses", 32'(pv), 0);
    reset = 1'b1;
    wait_cyc(2);

    fchg = 0;
    for (int i = 0; i < 12; i++) begin
      btn_mode = ((i / 2) % 2 == 0);
      wait_cyc(1);
    end
    btn_mode = 1'b1;
    wait_cyc(10);
    check("bounce_field", 32'(field_sel), 1);
    check("bounce_set", 32'(set_active), 1);
    check("bounce_once", fchg, 1);
    btn_mode = 1'b0;
    wait_cyc(8);

    clr();
    press(3'b100);
    check("ampm_hour", pc[6], 1);
    check("ampm_hour_add", add_sum(), 0);

    press(3'b001);
    check("to_min", 32'(field_sel), 2);

    clr();
    press(3'b011);
    check("simul_field", 32'(field_sel), 3);
    check("simul_no_min", pc[1], 0);
    check("simul_no_add", add_sum(), 0);

    press(3'b001);
    check("to_year", 32'(field_sel), 4);
    clr();
    press(3'b100);
    check("ampm_year", pc[6], 0);

    press(3'b001);
    check("to_month", 32'(field_sel), 5);

    clr();
    mq.delete();
    btn_inc = 1'b1;
    wait_cyc(38);
    btn_inc = 1'b0;
    wait_cyc(30);
    check("rep_count", mq.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("rep_off%0d", i),
            mq.size() > i ? mq[i] - mq[0] : -1, offs[i]);
    check("rep_month_pc", pc[4], 5);
    check("rep_others", add_sum() - pc[4], 0);
    check("rep_blink", 32'(blink), 1);

    press(3'b001);
    check("to_day", 32'(field_sel), 6);
    clr();
    wait_cyc(80);
    check("day_pre_tmo", 32'(field_sel), 6);
    wait_cyc(20);
    check("tmo_field", 32'(field_sel), 0);
    check("tmo_set", 32'(set_active), 0);
    check("tmo_pulses", add_sum() + pc[6], 0);

    for (int i = 1; i <= 7; i++) begin
      press(3'b001);
      check($sformatf("walk%0d_field", i), 32'(field_sel), i % 7);
      check($sformatf("walk%0d_set", i), 32'(set_active),
            (i != 7) ? 1 : 0);
    end

    press(3'b001);
    check("rst_hour", 32'(field_sel), 1);
    clr();
    btn_inc = 1'b1;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      wait_cyc(1);
      if (add_hour && pc[0] >= 2) begin
        found = 1;
        break;
      end
    end
    check("rst_rep_seen", found, 1);
    reset = 1'b0;
    #1;
    check("midrst_hour", 32'(add_hour), 0);
    check("midrst_pulses", 32'(pv), 0);
    check("midrst_field", 32'(field_sel), 0);
    check("midrst_set", 32'(set_active), 0);
    check("midrst_blink", 32'(blink), 1);
    btn_inc = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(4);
    check("post_rst_field", 32'(field_sel), 0);
    check("exclusive", multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
